// File: rtl/vga_tile_renderer.sv
// rtl/vga_tile_renderer.sv - tile/text-mode pixel generator with per-frame scroll and per-tile blink
module vga_tile_renderer #(
  parameter int   MAP_COLS_LOG2 = 7,
  parameter int   MAP_ROWS_LOG2 = 6,
  parameter int   BLINK_LOG2    = 5,
  parameter logic H_IDLE        = 1'b1,
  parameter logic V_IDLE        = 1'b1
) (
  input  logic                                   pixel_clock,
  input  logic                                   reset,
  input  logic [11:0]                            h_position,
  input  logic [11:0]                            v_position,
  input  logic                                   visible_area,
  input  logic                                   h_sync_in,
  input  logic                                   v_sync_in,
  input  logic [MAP_COLS_LOG2+2:0]               scroll_x,
  input  logic [MAP_ROWS_LOG2+2:0]               scroll_y,
  output logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] tile_addr,
  input  logic [15:0]                            tile_data,
  output logic [10:0]                            font_addr,
  input  logic [7:0]                             font_data,
  output logic [3:0]                             vga_red,
  output logic [3:0]                             vga_green,
  output logic [3:0]                             vga_blue,
  output logic                                   vga_horizontal_sync,
  output logic                                   vga_vertical_sync
);

  // scrolled pixel coordinate widths: 8 px per tile, so 3 extra bits below the tile index
  localparam int SX_W = MAP_COLS_LOG2 + 3;
  localparam int SY_W = MAP_ROWS_LOG2 + 3;

  // foreground channel level: intensity lifts both the lit and unlit levels
  function automatic logic [3:0] fg_level(input logic on, input logic intense);
    if (on) return intense ? 4'hF : 4'hA;
    else    return intense ? 4'h5 : 4'h0;
  endfunction

  logic [SX_W-1:0] shadow_x;
  logic [SY_W-1:0] shadow_y;
  logic [7:0]      frame_count;

  logic            frame_start;
  logic [SX_W-1:0] eff_x;
  logic [SY_W-1:0] eff_y;
  logic [SX_W-1:0] sx;
  logic [SY_W-1:0] sy;
  logic [7:0]      frame_count_next;

  // the frame-start pixel already uses the freshly sampled scroll and frame count
  assign frame_start      = (h_position == 12'd0) && (v_position == 12'd0);
  assign eff_x            = frame_start ? scroll_x : shadow_x;
  assign eff_y            = frame_start ? scroll_y : shadow_y;
  assign sx               = h_position[SX_W-1:0] + eff_x;
  assign sy               = v_position[SY_W-1:0] + eff_y;
  assign frame_count_next = frame_start ? frame_count + 8'd1 : frame_count;

  logic [2:0] fine_x_s1, fine_x_s2, fine_x_s3, fine_x_s4;
  logic [2:0] glyph_row_s1, glyph_row_s2;
  logic       phase_s1, phase_s2;
  logic [3:0] fg_s3, fg_s4;
  logic [2:0] bg_s3, bg_s4;
  logic       blink_s3, blink_s4;
  logic [3:0] vis_dl;
  logic [4:0] hs_dl, vs_dl;

  // E1: scroll shadow, frame counter, tile address and per-pixel coordinates
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      shadow_x     <= '0;
      shadow_y     <= '0;
      frame_count  <= 8'd0;
      tile_addr    <= '0;
      fine_x_s1    <= 3'd0;
      glyph_row_s1 <= 3'd0;
      phase_s1     <= 1'b0;
    end else begin
      if (frame_start) begin
        shadow_x <= scroll_x;
        shadow_y <= scroll_y;
      end
      frame_count  <= frame_count_next;
      tile_addr    <= {sy[SY_W-1:3], sx[SX_W-1:3]};
      fine_x_s1    <= sx[2:0];
      glyph_row_s1 <= sy[2:0];
      phase_s1     <= frame_count_next[BLINK_LOG2];
    end
  end

  // E2: hold coordinates while the tile RAM read is in flight
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      fine_x_s2    <= 3'd0;
      glyph_row_s2 <= 3'd0;
      phase_s2     <= 1'b0;
    end else begin
      fine_x_s2    <= fine_x_s1;
      glyph_row_s2 <= glyph_row_s1;
      phase_s2     <= phase_s1;
    end
  end

  // E3: font address from the fetched glyph, latch colour and blink attributes
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      font_addr <= 11'd0;
      fg_s3     <= 4'd0;
      bg_s3     <= 3'd0;
      blink_s3  <= 1'b0;
      fine_x_s3 <= 3'd0;
    end else begin
      font_addr <= {tile_data[7:0], glyph_row_s2};
      fg_s3     <= tile_data[11:8];
      bg_s3     <= tile_data[14:12];
      blink_s3  <= tile_data[15] & phase_s2;
      fine_x_s3 <= fine_x_s2;
    end
  end

  // E4: hold attributes while the font ROM read is in flight
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      fg_s4     <= 4'd0;
      bg_s4     <= 3'd0;
      blink_s4  <= 1'b0;
      fine_x_s4 <= 3'd0;
    end else begin
      fg_s4     <= fg_s3;
      bg_s4     <= bg_s3;
      blink_s4  <= blink_s3;
      fine_x_s4 <= fine_x_s3;
    end
  end

  // visible and sync delay line; syncs leave straight from the last stage
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      vis_dl <= 4'b0000;
      hs_dl  <= {5{H_IDLE}};
      vs_dl  <= {5{V_IDLE}};
    end else begin
      vis_dl <= {vis_dl[2:0], visible_area};
      hs_dl  <= {hs_dl[3:0], h_sync_in};
      vs_dl  <= {vs_dl[3:0], v_sync_in};
    end
  end

  assign vga_horizontal_sync = hs_dl[4];
  assign vga_vertical_sync   = vs_dl[4];

  logic       pix_on;
  logic [3:0] red_next, green_next, blue_next;

  // pixel colour select; blink forces the background, blanking forces black
  always_comb begin
    red_next   = 4'h0;
    green_next = 4'h0;
    blue_next  = 4'h0;
    pix_on     = font_data[3'd7 - fine_x_s4] & ~blink_s4;
    if (vis_dl[3]) begin
      if (pix_on) begin
        red_next   = fg_level(fg_s4[2], fg_s4[3]);
        green_next = fg_level(fg_s4[1], fg_s4[3]);
        blue_next  = fg_level(fg_s4[0], fg_s4[3]);
      end else begin
        red_next   = bg_s4[2] ? 4'hA : 4'h0;
        green_next = bg_s4[1] ? 4'hA : 4'h0;
        blue_next  = bg_s4[0] ? 4'hA : 4'h0;
      end
    end
  end

  // E5: registered RGB
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      vga_red   <= 4'h0;
      vga_green <= 4'h0;
      vga_blue  <= 4'h0;
    end else begin
      vga_red   <= red_next;
      vga_green <= green_next;
      vga_blue  <= blue_next;
    end
  end

endmodule
